// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn sequencer: owns the board, alternates X/O play strobes,
// waits out win/draw evaluation, forfeits slow turns and keeps the match score.
module turn_sequencer #(
  parameter int unsigned TURN_CYCLES = 50_000_000,
  parameter int unsigned SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reqX,
  input  logic               reqO,
  input  logic               new_game,
  input  logic               illegal_move,
  input  logic               win,
  input  logic [1:0]         who,
  input  logic               no_space,
  output logic               playX,
  output logic               playO,
  output logic               board_clr,
  output logic               turn,
  output logic               game_over,
  output logic               draw,
  output logic               timeout,
  output logic               bad_move,
  output logic [SCORE_W-1:0] scoreX,
  output logic [SCORE_W-1:0] scoreO
);

  localparam int unsigned CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    (TURN_CYCLES == 0) ? '0 : CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    CLEAR, WAIT_X, ISSUE_X, CHECK_X, WAIT_O, ISSUE_O, CHECK_O, OVER
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               starter_q, starter_d;
  logic               turn_q, turn_d;
  logic               draw_q, draw_d;
  logic               timeout_q, timeout_d;
  logic               bad_q, bad_d;
  logic [SCORE_W-1:0] scx_q, scx_d;
  logic [SCORE_W-1:0] sco_q, sco_d;
  logic               prev_x_q, prev_o_q, prev_n_q;

  logic x_edge, o_edge, n_edge, expire;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign x_edge = reqX & ~prev_x_q;
  assign o_edge = reqO & ~prev_o_q;
  assign n_edge = new_game & ~prev_n_q;
  assign expire = (TURN_CYCLES != 0) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starter_d = starter_q;
    draw_d    = draw_q;
    timeout_d = 1'b0;
    bad_d     = 1'b0;
    scx_d     = scx_q;
    sco_d     = sco_q;
    turn_d    = turn_q;

    if (n_edge) begin
      // Only a finished game hands the opening move to the other player.
      state_d = CLEAR;
      cnt_d   = '0;
      draw_d  = 1'b0;
      if (state_q == OVER) starter_d = ~starter_q;
    end else begin
      case (state_q)
        CLEAR: begin
          state_d = starter_q ? WAIT_O : WAIT_X;
          cnt_d   = '0;
        end
        WAIT_X: begin
          if (x_edge) begin
            state_d = ISSUE_X;
          end else if (expire) begin
            state_d   = WAIT_O;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else if (TURN_CYCLES != 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_O: begin
          if (o_edge) begin
            state_d = ISSUE_O;
          end else if (expire) begin
            state_d   = WAIT_X;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else if (TURN_CYCLES != 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ISSUE_X: begin
          if (illegal_move) begin
            state_d = WAIT_X;
            bad_d   = 1'b1;
          end else begin
            state_d = CHECK_X;
          end
        end
        ISSUE_O: begin
          if (illegal_move) begin
            state_d = WAIT_O;
            bad_d   = 1'b1;
          end else begin
            state_d = CHECK_O;
          end
        end
        CHECK_X, CHECK_O: begin
          if (win) begin
            state_d = OVER;
            if (who == 2'b01) scx_d = sat_inc(scx_q);
            else if (who == 2'b10) sco_d = sat_inc(sco_q);
          end else if (no_space) begin
            state_d = OVER;
            draw_d  = 1'b1;
          end else begin
            state_d = (state_q == CHECK_X) ? WAIT_O : WAIT_X;
            cnt_d   = '0;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = CLEAR;
      endcase
    end

    // In CLEAR show the upcoming mover; in OVER keep the last mover.
    case (state_d)
      WAIT_X, ISSUE_X, CHECK_X: turn_d = 1'b0;
      WAIT_O, ISSUE_O, CHECK_O: turn_d = 1'b1;
      CLEAR:                    turn_d = starter_d;
      default:                  turn_d = turn_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      starter_q <= 1'b0;
      turn_q    <= 1'b0;
      draw_q    <= 1'b0;
      timeout_q <= 1'b0;
      bad_q     <= 1'b0;
      scx_q     <= '0;
      sco_q     <= '0;
      prev_x_q  <= 1'b1;
      prev_o_q  <= 1'b1;
      prev_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starter_q <= starter_d;
      turn_q    <= turn_d;
      draw_q    <= draw_d;
      timeout_q <= timeout_d;
      bad_q     <= bad_d;
      scx_q     <= scx_d;
      sco_q     <= sco_d;
      prev_x_q  <= reqX;
      prev_o_q  <= reqO;
      prev_n_q  <= new_game;
    end
  end

  assign playX     = (state_q == ISSUE_X);
  assign playO     = (state_q == ISSUE_O);
  assign board_clr = (state_q == CLEAR);
  assign game_over = (state_q == OVER);
  assign turn      = turn_q;
  assign draw      = draw_q;
  assign timeout   = timeout_q;
  assign bad_move  = bad_q;
  assign scoreX    = scx_q;
  assign scoreO    = sco_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: a game-level reference model predicts
// every observable event; a monitor compares each event the DUT presents.
module tb_turn_sequencer;
  localparam int T    = 8;
  localparam int SW   = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reqX = 1'b0, reqO = 1'b0, new_game = 1'b0;
  logic illegal_move = 1'b0, win = 1'b0, no_space = 1'b0;
  logic [1:0] who = 2'b00;
  logic playX, playO, board_clr, turn, game_over, draw, timeout, bad_move;
  logic [SW-1:0] scoreX, scoreO;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  turn_sequencer #(.TURN_CYCLES(T), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .reqX(reqX), .reqO(reqO), .new_game(new_game),
    .illegal_move(illegal_move), .win(win), .who(who), .no_space(no_space),
    .playX(playX), .playO(playO), .board_clr(board_clr), .turn(turn),
    .game_over(game_over), .draw(draw), .timeout(timeout), .bad_move(bad_move),
    .scoreX(scoreX), .scoreO(scoreO)
  );

  // Reference model: who is to move, which step of the turn, and match totals.
  bit m_clear, m_over, m_mover, m_starter, m_draw, m_to, m_bad;
  bit m_px, m_po, m_pn;
  int m_step, m_waited, m_scx, m_sco;
  logic [11:0] exp_q[$];

  task automatic model_reset();
    m_clear = 1; m_over = 0; m_mover = 0; m_starter = 0; m_draw = 0;
    m_to = 0; m_bad = 0; m_px = 1; m_po = 1; m_pn = 1;
    m_step = 0; m_waited = 0; m_scx = 0; m_sco = 0;
  endtask

  task automatic model_step();
    bit ex, eo, en, e, px, po, clr;
    logic [11:0] v;
    if (!rst) begin
      model_reset();
      return;
    end
    ex = reqX && !m_px;
    eo = reqO && !m_po;
    en = new_game && !m_pn;
    m_px = reqX; m_po = reqO; m_pn = new_game;
    m_to = 0; m_bad = 0;
    if (en) begin
      if (m_over) m_starter = !m_starter;
      m_over = 0; m_clear = 1; m_draw = 0; m_mover = m_starter; m_step = 0;
    end else if (m_clear) begin
      m_clear = 0; m_mover = m_starter; m_step = 0; m_waited = 0;
    end else if (!m_over) begin
      if (m_step == 0) begin
        e = m_mover ? eo : ex;
        if (e) m_step = 1;
        else if (m_waited == T - 1) begin
          m_to = 1; m_mover = !m_mover; m_waited = 0;
        end else m_waited++;
      end else if (m_step == 1) begin
        if (illegal_move) begin m_bad = 1; m_step = 0; end
        else m_step = 2;
      end else begin
        if (win) begin
          m_over = 1;
          if (who == 2'b01) m_scx = (m_scx == SMAX) ? SMAX : m_scx + 1;
          else if (who == 2'b10) m_sco = (m_sco == SMAX) ? SMAX : m_sco + 1;
        end else if (no_space) begin
          m_over = 1; m_draw = 1;
        end else begin
          m_mover = !m_mover; m_step = 0; m_waited = 0;
        end
      end
    end
    clr = m_clear;
    px = !m_clear && !m_over && m_step == 1 && !m_mover;
    po = !m_clear && !m_over && m_step == 1 && m_mover;
    v = {px, po, clr, m_to, m_bad, m_over, m_over && m_draw, m_mover,
         2'(m_scx), 2'(m_sco)};
    if (px || po || clr || m_to || m_bad || m_over) exp_q.push_back(v);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: every cycle the DUT shows a pulse or game_over is one event.
  initial begin
    logic [11:0] got, ex;
    forever begin
      @(negedge clk);
      if (rst) begin
        got = {playX, playO, board_clr, timeout, bad_move, game_over, draw, turn,
               scoreX, scoreO};
        if (playX || playO || board_clr || timeout || bad_move || game_over) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event t=%0t got=%b required=none", $time, got);
          end else begin
            ex = exp_q.pop_front();
            if (got !== ex) begin
              fails++;
              $display("FAIL event t=%0t got=%b required=%b", $time, got, ex);
            end
          end
        end
        if (exp_q.size() != 0) begin
          tests++; fails++;
          $display("FAIL missing_event t=%0t got=none required=%b", $time, exp_q[0]);
          exp_q.delete();
        end
      end
    end
  end

  task automatic check(string nm, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs",
            int'({playX, playO, board_clr, timeout, bad_move, game_over, draw, turn,
                  scoreX, scoreO}), 12'h200);
    end
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic play(bit o, bit ill, bit w, logic [1:0] wh, bit ns);
    if (o) reqO = 1'b1; else reqX = 1'b1;
    tick();
    reqX = 1'b0; reqO = 1'b0; illegal_move = ill;
    tick();
    illegal_move = 1'b0; win = w; who = wh; no_space = ns;
    tick();
    win = 1'b0; who = 2'b00; no_space = 1'b0;
  endtask

  task automatic ng();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
  endtask

  initial begin
    bit s;
    bit seen;
    // Power-up reset and an X win with a rejected O move in the middle.
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs",
            int'({playX, playO, board_clr, timeout, bad_move, game_over, draw, turn,
                  scoreX, scoreO}), 12'h200);
    end
    #1 rst = 1'b1;
    tick();
    play(0, 0, 0, 2'b00, 0);
    reqX = 1'b1; tick(); reqX = 1'b0; tick();
    play(1, 1, 0, 2'b00, 0);
    check("turn_after_bad_move", int'(turn), 1);
    play(1, 0, 0, 2'b00, 0);
    play(0, 0, 0, 2'b00, 0);
    reqO = 1'b1; tick(); reqO = 1'b0; tick();
    play(1, 0, 0, 2'b00, 0);
    play(0, 0, 1, 2'b01, 0);
    check("x_win_over", int'(game_over), 1);
    check("x_win_score", int'(scoreX), 1);
    check("x_win_nodraw", int'(draw), 0);

    // Draw, then the next game opens with O.
    ng();
    check("starter_toggle_turn", int'(turn), 1);
    play(1, 0, 0, 2'b00, 1);
    check("draw_flag", int'(draw), 1);
    check("draw_scores", int'({scoreX, scoreO}), 4'b0100);

    // Abort mid-game keeps X as the opener.
    ng();
    play(0, 0, 0, 2'b00, 0);
    ng();
    check("abort_keeps_starter", int'(turn), 0);

    // Four more X wins saturate the 2-bit counter.
    s = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if (s) play(1, 0, 0, 2'b00, 0);
      play(0, 0, 0, 2'b00, 0);
      play(1, 0, 0, 2'b00, 0);
      play(0, 0, 0, 2'b00, 0);
      play(1, 0, 0, 2'b00, 0);
      play(0, 0, 1, 2'b01, 0);
      ng();
      s = !s;
    end
    check("score_saturates", int'(scoreX), SMAX);

    // Idle until a turn is forfeited, then press on the last cycle of the next turn.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (timeout) seen = 1'b1;
    end
    check("timeout_seen", int'(seen), 1);
    repeat (7) @(posedge clk);
    #1;
    if (turn) reqO = 1'b1; else reqX = 1'b1;
    tick();
    reqX = 1'b0; reqO = 1'b0;
    repeat (3) tick();

    // Reset mid-game with reqX held: no move until released and pressed again.
    reqX = 1'b1;
    do_reset();
    repeat (5) tick();
    reqX = 1'b0; tick();
    reqX = 1'b1; tick();
    reqX = 1'b0;
    repeat (3) tick();

    // Randomised play.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      reqX         = ($urandom_range(0, 2) == 0);
      reqO         = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 30) == 0) new_game = ~new_game;
      illegal_move = ($urandom_range(0, 4) == 0);
      win          = ($urandom_range(0, 3) == 0);
      who          = 2'($urandom_range(0, 3));
      no_space     = ($urandom_range(0, 4) == 0);
      tick();
    end
    reqX = 1'b0; reqO = 1'b0; illegal_move = 1'b0; win = 1'b0; no_space = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game controller sitting between the player push-button inputs and the tic-tac-toe board datapath: position registers, winner detector, illegal-move and no-space detectors. It enforces strict X/O alternation and issues one-cycle play strobes. It waits out the board's win/draw evaluation, applies a per-turn timeout that forfeits the turn, and keeps a running match score. It replaces free-running play strobes with a single sequenced owner of the board.

## Interface
- TURN_CYCLES, 50_000_000: clock cycles a player has to move; 0 disables the timeout.
- SCORE_W, 4: width of each score counter.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- reqX  input  1  player X move button, level, synchronised upstream.
- reqO  input  1  player O move button, level, synchronised upstream.
- new_game  input  1  level; rising edge starts a new game.
- illegal_move  input  1  board: current move targets an occupied or invalid cell.
- win  input  1  board: a line is complete.
- who  input  2  board winner; 01 = X, 10 = O, 00 = none.
- no_space  input  1  board: all nine cells filled.
- playX  output  1  one-cycle strobe committing X's position to the board.
- playO  output  1  one-cycle strobe committing O's position to the board.
- board_clr  output  1  one-cycle synchronous clear to the position registers.
- turn  output  1  0 = X to move, 1 = O to move.
- game_over  output  1  high while in OVER.
- draw  output  1  high in OVER when the game ended without a winner.
- timeout  output  1  one-cycle pulse when a turn is forfeited.
- bad_move  output  1  one-cycle pulse when a strobe was rejected as illegal.
- scoreX  output  SCORE_W  games won by X, saturating.
- scoreO  output  SCORE_W  games won by O, saturating.

## Operation
- Internal edge detectors on reqX, reqO and new_game use registered previous values. An edge means current = 1 and previous = 0.
- States: CLEAR, WAIT_X, ISSUE_X, CHECK_X, WAIT_O, ISSUE_O, CHECK_O, OVER.
- **CLEAR:** board_clr = 1 for one cycle, then go to WAIT of the starting player.
- **WAIT_X:**
  - reqX edge → ISSUE_X.
  - reqO edges are ignored.
  - Timeout counter increments each cycle.
  - At count = TURN_CYCLES−1 with no reqX edge: timeout pulse, go to WAIT_O.
  - If the edge and the expiry occur in the same cycle, the edge wins.
- **ISSUE_X:** playX = 1 for exactly one cycle; illegal_move is sampled in this cycle.
  - illegal_move = 1 → bad_move pulse, return to WAIT_X. The timeout counter is not restarted.
  - Otherwise → CHECK_X.
- **CHECK_X:** the board registers now hold the move; win and no_space are sampled.
  - win = 1 → OVER. who = 01 increments scoreX; who = 10 increments scoreO. Scores saturate at all-ones.
  - win = 0 and no_space = 1 → OVER with draw = 1.
  - Otherwise → WAIT_O, with the timeout counter cleared on entry.
- WAIT_O, ISSUE_O and CHECK_O mirror the X states with X/O swapped.
- **OVER:** holds the board unchanged; all req edges are ignored.
- **Starting player:** X after reset. The starter toggles on each CLEAR entered from OVER.
- **new_game edge:** from any state, go to CLEAR next cycle.
  - An abort (new_game taken from any state other than OVER) leaves the starter and the scores unchanged.
  - new_game has priority over every other transition in that cycle.
- turn = 0 in X states; turn = 1 in O states. In CLEAR and OVER, turn is the value of the next/last mover respectively.
- The timeout counter must be wide enough to reach TURN_CYCLES−1. With TURN_CYCLES = 0 the counter is held at 0 and timeout never pulses.

## Timing
- **Reset (rst = 0):**
  - State goes to CLEAR.
  - Outputs: board_clr = 1, playX = playO = 0, turn = 0, game_over = draw = timeout = bad_move = 0, scoreX = scoreO = 0.
  - Edge-detector history is set to 1, so a held button does not fire after reset.
  - Timeout counter = 0.
- **After rst rises:** CLEAR lasts one cycle, then WAIT_X.
- **Move latency:**
  - Edge seen at cycle N → playX high at N+1.
  - CHECK at N+2.
  - Next WAIT, or OVER, at N+3.
- All outputs are registered (Moore); pulses are exactly one cycle.
- A button held high produces one move only; it must return low before the next edge.
- rst asserted mid-game aborts immediately (asynchronously); scores are lost.

## Test plan
- **Reset then X win.** Stimulus: reset; X plays cells 1, 2, 3 and O plays 4, 5, with the board model asserting win, who = 01 after X's third CHECK. Required: exactly five single-cycle strobes, alternating playX/playO; game_over = 1; scoreX = 1; draw = 0.
- **Illegal move.** Stimulus: drive illegal_move = 1 during ISSUE_O. Required: bad_move pulse; state returns to WAIT_O; turn stays 1; the next legal reqO edge issues playO.
- **Timeout.** Stimulus: TURN_CYCLES = 8, no request. Required: timeout pulses 8 cycles after entering WAIT_X; turn becomes 1. Edge arriving on expiry cycle 7: playX issued and no timeout.
- **Draw and starter toggle.** Stimulus: no_space = 1 at CHECK with win = 0, then a new_game edge. Required: draw = 1 with scores unchanged; then board_clr pulse; turn = 1 (O starts) in the next game.
- **Abort and saturation.** Stimulus: new_game mid-turn; then SCORE_W = 2 with four X wins. Required: the abort clears the board and keeps the starter; scoreX saturates at 3.
- **Cross-player and reset.** Stimulus: reqO edges during an X turn; rst pulse mid-game with reqX held high. Required: reqO edges ignored; reset clears all outputs, and the held reqX produces no move until it is released and pressed again.
